mvm_rr_arbiter: RTL and testbench

- Shares the single AXI-Stream matrix-vector multiplier (KX in, Y out) between two requesters, e.g. UART host path and on-chip self-test source.
- Round-robin arbitration on KX jobs through a registered issue stage.
- Records the requester ID of every issued job in a tag FIFO.
- Routes each returning Y result to the requester that issued the job, in order; supports up to DEPTH jobs in flight in a pipelined multiplier.

---
 rtl/mvm_rr_arbiter.sv | 93 +++++++++
 tb/tb_mvm_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_rr_arbiter.sv
// mvm_rr_arbiter: round-robin sharing of one AXIS matrix-vector multiplier between two requesters,
// with an in-order tag FIFO that routes each Y result back to the requester that issued its job.
module mvm_rr_arbiter #(
    parameter int W_KX  = 576,
    parameter int W_Y   = 152,
    parameter int DEPTH = 4,
    localparam int W_C  = $clog2(DEPTH + 1),
    localparam int W_P  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_kx_tvalid,
    output logic            s0_kx_tready,
    input  logic [W_KX-1:0] s0_kx_tdata,
    input  logic            s1_kx_tvalid,
    output logic            s1_kx_tready,
    input  logic [W_KX-1:0] s1_kx_tdata,
    output logic            m_kx_tvalid,
    input  logic            m_kx_tready,
    output logic [W_KX-1:0] m_kx_tdata,
    input  logic            s_y_tvalid,
    output logic            s_y_tready,
    input  logic [W_Y-1:0]  s_y_tdata,
    output logic            m0_y_tvalid,
    input  logic            m0_y_tready,
    output logic [W_Y-1:0]  m0_y_tdata,
    output logic            m1_y_tvalid,
    input  logic            m1_y_tready,
    output logic [W_Y-1:0]  m1_y_tdata,
    output logic [W_C-1:0]  outstanding,
    output logic            err_orphan
);
    logic            r_full;
    logic [W_KX-1:0] r_data;
    logic            r_ptr;
    logic [DEPTH-1:0] r_tag;
    logic [W_P-1:0]  r_wp;
    logic [W_P-1:0]  r_rp;
    logic [W_C-1:0]  r_cnt;
    logic            r_err;
    logic            w_load_en;
    logic            w_g0;
    logic            w_g1;
    logic            w_push;
    logic            w_pop;
    logic            w_nempty;
    logic            w_head;
    // The tag is pushed at load, so the count already covers the job held in the issue slot.
    assign w_load_en    = !rst && (!r_full || m_kx_tready) && (r_cnt < W_C'(DEPTH));
    assign w_g0         = w_load_en && s0_kx_tvalid && (!s1_kx_tvalid || !r_ptr);
    assign w_g1         = w_load_en && s1_kx_tvalid && (!s0_kx_tvalid || r_ptr);
    assign w_push       = w_g0 || w_g1;
    assign w_nempty     = r_cnt != '0;
    assign w_head       = r_tag[r_rp];
    assign w_pop        = s_y_tvalid && s_y_tready;
    assign s0_kx_tready = w_g0;
    assign s1_kx_tready = w_g1;
    assign m_kx_tvalid  = r_full;
    assign m_kx_tdata   = r_data;
    assign s_y_tready   = !rst && w_nempty && (w_head ? m1_y_tready : m0_y_tready);
    assign m0_y_tvalid  = !rst && s_y_tvalid && w_nempty && !w_head;
    assign m1_y_tvalid  = !rst && s_y_tvalid && w_nempty && w_head;
    assign m0_y_tdata   = s_y_tdata;
    assign m1_y_tdata   = s_y_tdata;
    assign outstanding  = r_cnt;
    assign err_orphan   = r_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_ptr  <= 1'b0;
            r_tag  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_full       <= 1'b1;
                r_data       <= w_g1 ? s1_kx_tdata : s0_kx_tdata;
                r_ptr        <= w_g0;
                r_tag[r_wp]  <= w_g1;
                r_wp         <= r_wp + 1'b1;
            end else if (m_kx_tready) begin
                r_full <= 1'b0;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + W_C'(w_push) - W_C'(w_pop);
            r_err <= r_err || (s_y_tvalid && !w_nempty);
        end
    end
endmodule

// File: tb/tb_mvm_rr_arbiter.sv
// tb_mvm_rr_arbiter: directed and randomized stimulus checked every cycle against a queue-based
// reference model, plus literal expectations for the key arbitration and routing scenarios.
module tb_mvm_rr_arbiter;
    localparam int W_KX = 576;
    localparam int W_Y = 152;
    localparam int DEPTH = 4;
    localparam int W_C = $clog2(DEPTH + 1);
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0v = 1'b0, s1v = 1'b0, mkr = 1'b0, syv = 1'b0, m0r = 1'b0, m1r = 1'b0;
    logic [W_KX-1:0] s0d = '0, s1d = '0;
    logic [W_Y-1:0] syd = '0;
    logic s0_kx_tready, s1_kx_tready, m_kx_tvalid, s_y_tready, m0_y_tvalid, m1_y_tvalid, err_orphan;
    logic [W_KX-1:0] m_kx_tdata;
    logic [W_Y-1:0] m0_y_tdata, m1_y_tdata;
    logic [W_C-1:0] outstanding;

    mvm_rr_arbiter #(.W_KX(W_KX), .W_Y(W_Y), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_kx_tvalid(s0v), .s0_kx_tready(s0_kx_tready), .s0_kx_tdata(s0d),
        .s1_kx_tvalid(s1v), .s1_kx_tready(s1_kx_tready), .s1_kx_tdata(s1d),
        .m_kx_tvalid(m_kx_tvalid), .m_kx_tready(mkr), .m_kx_tdata(m_kx_tdata),
        .s_y_tvalid(syv), .s_y_tready(s_y_tready), .s_y_tdata(syd),
        .m0_y_tvalid(m0_y_tvalid), .m0_y_tready(m0r), .m0_y_tdata(m0_y_tdata),
        .m1_y_tvalid(m1_y_tvalid), .m1_y_tready(m1r), .m1_y_tdata(m1_y_tdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    task automatic chk(string nm, logic [W_KX-1:0] act, logic [W_KX-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: issue slot contents, favoured requester, queue of requester IDs in flight
    logic m_full = 1'b0;
    logic [W_KX-1:0] m_data = '0;
    logic m_ptr = 1'b0;
    logic m_err = 1'b0;
    bit q[$];
    bit chk_on = 1'b0;

    // observations shared with the stimulus side
    logic hs_s0 = 0, hs_s1 = 0, hs_mkx = 0, hs_sy = 0;
    logic [W_KX-1:0] cap_kx = '0;
    bit gq[$];
    bit rxid[$];
    logic [W_Y-1:0] rx0[$];
    logic [W_Y-1:0] rx1[$];
    int peak = 0, n_grant = 0;

    always @(negedge clk) begin : cp
        bit ld, g0, g1, nz, hd, esy;
        if (chk_on) begin
            ld = !rst && (!m_full || mkr) && (q.size() < DEPTH);
            g0 = ld && s0v && (!s1v || !m_ptr);
            g1 = ld && s1v && (!s0v || m_ptr);
            nz = q.size() > 0;
            hd = nz ? q[0] : 1'b0;
            esy = !rst && nz && (hd ? m1r : m0r);
            chk("s0_kx_tready", W_KX'(s0_kx_tready), W_KX'(g0));
            chk("s1_kx_tready", W_KX'(s1_kx_tready), W_KX'(g1));
            chk("m_kx_tvalid", W_KX'(m_kx_tvalid), W_KX'(m_full));
            chk("m_kx_tdata", m_kx_tdata, m_data);
            chk("s_y_tready", W_KX'(s_y_tready), W_KX'(esy));
            chk("m0_y_tvalid", W_KX'(m0_y_tvalid), W_KX'(!rst && syv && nz && !hd));
            chk("m1_y_tvalid", W_KX'(m1_y_tvalid), W_KX'(!rst && syv && nz && hd));
            chk("m0_y_tdata", W_KX'(m0_y_tdata), W_KX'(syd));
            chk("m1_y_tdata", W_KX'(m1_y_tdata), W_KX'(syd));
            chk("outstanding", W_KX'(outstanding), W_KX'(q.size()));
            chk("err_orphan", W_KX'(err_orphan), W_KX'(m_err));
            hs_s0 = s0v && s0_kx_tready;
            hs_s1 = s1v && s1_kx_tready;
            hs_mkx = m_kx_tvalid && mkr;
            hs_sy = syv && s_y_tready;
            cap_kx = m_kx_tdata;
            if (hs_s0) gq.push_back(1'b0);
            if (hs_s1) gq.push_back(1'b1);
            if (hs_s0 || hs_s1) n_grant++;
            if (m0_y_tvalid && m0r) begin rx0.push_back(m0_y_tdata); rxid.push_back(1'b0); end
            if (m1_y_tvalid && m1r) begin rx1.push_back(m1_y_tdata); rxid.push_back(1'b1); end
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (rst) begin
                m_full = 1'b0; m_data = '0; m_ptr = 1'b0; m_err = 1'b0; q.delete();
            end else begin
                if (syv && !nz) m_err = 1'b1;
                if (syv && esy) q.delete(0);
                if (g0 || g1) begin
                    q.push_back(g1);
                    m_full = 1'b1;
                    m_data = g1 ? s1d : s0d;
                    m_ptr = g0;
                end else if (mkr) m_full = 1'b0;
            end
        end
    end

    // stimulus side: requesters, and a multiplier returning Y = job + 1 after a latency
    logic [W_Y-1:0] mq[$];
    int mdue[$];
    int cyc = 0, lat_max = 0, n0 = 0, n1 = 0, p0 = 100, p1 = 100;
    int j0 = 'h100, j1 = 'h200;
    bit y_en = 0, y_force = 0, rand_rdy = 0, rnd_data = 0;

    function automatic logic [W_KX-1:0] rndkx();
        logic [W_KX-1:0] r;
        for (int i = 0; i < W_KX / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic upd();
        if (hs_sy && mq.size() > 0) begin mq.delete(0); mdue.delete(0); end
        if (hs_mkx) begin
            mq.push_back(cap_kx[W_Y-1:0] + W_Y'(1));
            mdue.push_back(cyc + int'($urandom_range(lat_max)));
        end
        if (rand_rdy) begin
            mkr = $urandom_range(3) != 0;
            m0r = $urandom_range(3) != 0;
            m1r = $urandom_range(3) != 0;
            y_en = $urandom_range(3) != 0;
        end
        if (!y_force) begin
            if (!(syv && !hs_sy)) syv = y_en && mq.size() > 0 && mdue[0] <= cyc;
            syd = mq.size() > 0 ? mq[0] : '0;
        end
        if (hs_s0 && n0 > 0) n0--;
        if (hs_s1 && n1 > 0) n1--;
        if (!(s0v && !hs_s0)) begin
            s0v = n0 != 0 && int'($urandom_range(99)) < p0;
            if (s0v) begin s0d = rnd_data ? rndkx() : W_KX'(j0); j0++; end
        end
        if (!(s1v && !hs_s1)) begin
            s1v = n1 != 0 && int'($urandom_range(99)) < p1;
            if (s1v) begin s1d = rnd_data ? rndkx() : W_KX'(j1); j1++; end
        end
        hs_s0 = 0; hs_s1 = 0; hs_mkx = 0; hs_sy = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        upd();
    endtask

    task automatic reset_dut();
        n0 = 0; n1 = 0; s0v = 0; s1v = 0; syv = 0; y_force = 0;
        mq.delete(); mdue.delete();
        rst = 1;
        step();
        rst = 0;
        j0 = 'h100; j1 = 'h200; p0 = 100; p1 = 100; lat_max = 0;
        gq.delete(); rxid.delete(); rx0.delete(); rx1.delete();
        peak = 0; n_grant = 0;
    endtask

    initial begin
        rst = 1;
        step();
        chk_on = 1;
        // single requester, three jobs back to back
        reset_dut();
        mkr = 1; m0r = 1; m1r = 1; y_en = 1; n0 = 3;
        upd();
        repeat (12) step();
        @(negedge clk);
        chk("t1_rx0_cnt", W_KX'(rx0.size()), 3);
        chk("t1_rx0_a", W_KX'(rx0[0]), 'h101);
        chk("t1_rx0_b", W_KX'(rx0[1]), 'h102);
        chk("t1_rx0_c", W_KX'(rx0[2]), 'h103);
        chk("t1_rx1_cnt", W_KX'(rx1.size()), 0);
        chk("t1_peak", W_KX'(peak), 2);
        chk("t1_outstanding", W_KX'(outstanding), 0);
        // both requesters valid: grants and results alternate starting with 0
        reset_dut();
        n0 = 100; n1 = 100;
        upd();
        repeat (10) step();
        n0 = 0; n1 = 0;
        repeat (15) step();
        @(negedge clk);
        chk("t2_gq_cnt", W_KX'(gq.size() >= 4), 1);
        chk("t2_g0", W_KX'(gq[0]), 0);
        chk("t2_g1", W_KX'(gq[1]), 1);
        chk("t2_g2", W_KX'(gq[2]), 0);
        chk("t2_g3", W_KX'(gq[3]), 1);
        chk("t2_rxid_cnt", W_KX'(rxid.size() >= 4), 1);
        chk("t2_r0", W_KX'(rxid[0]), 0);
        chk("t2_r1", W_KX'(rxid[1]), 1);
        chk("t2_r2", W_KX'(rxid[2]), 0);
        chk("t2_r3", W_KX'(rxid[3]), 1);
        chk("t2_rx0_first", W_KX'(rx0[0]), 'h101);
        chk("t2_rx1_first", W_KX'(rx1[0]), 'h201);
        // results withheld: issue stops at DEPTH tags, one release reopens it a cycle later
        reset_dut();
        y_en = 0; n0 = 100; n1 = 100;
        upd();
        repeat (10) step();
        @(negedge clk);
        chk("t3_outstanding", W_KX'(outstanding), 4);
        chk("t3_grants", W_KX'(n_grant), 4);
        chk("t3_s0_ready", W_KX'(s0_kx_tready), 0);
        chk("t3_s1_ready", W_KX'(s1_kx_tready), 0);
        chk("t3_mkx_valid", W_KX'(m_kx_tvalid), 0);
        y_en = 1;
        step();
        y_en = 0;
        @(negedge clk);
        chk("t3_pop_sy_ready", W_KX'(s_y_tready), 1);
        chk("t3_pop_kx_ready", W_KX'(s0_kx_tready | s1_kx_tready), 0);
        step();
        @(negedge clk);
        chk("t3_after_kx_ready", W_KX'(s0_kx_tready | s1_kx_tready), 1);
        n0 = 0; n1 = 0; y_en = 1;
        repeat (20) step();
        // multiplier back-pressure holds the issue slot
        reset_dut();
        mkr = 0; n0 = 2;
        upd();
        step();
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_data", m_kx_tdata, 'h100);
            chk("t4_hold_valid", W_KX'(m_kx_tvalid), 1);
            chk("t4_s0_ready", W_KX'(s0_kx_tready), 0);
            chk("t4_outstanding", W_KX'(outstanding), 1);
            step();
        end
        mkr = 1;
        repeat (10) step();
        // blocked head requester 1 stalls a following result for requester 0
        reset_dut();
        m0r = 1; m1r = 0; n1 = 1;
        upd();
        step();
        n0 = 1;
        upd();
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_sy_ready", W_KX'(s_y_tready), 0);
            chk("t5_m1_valid", W_KX'(m1_y_tvalid), 1);
            chk("t5_m0_valid", W_KX'(m0_y_tvalid), 0);
            if (i < 2) step();
        end
        step();
        m1r = 1;
        @(negedge clk);
        chk("t5_release_ready", W_KX'(s_y_tready), 1);
        chk("t5_release_data", W_KX'(m1_y_tdata), 'h201);
        repeat (6) step();
        @(negedge clk);
        chk("t5_rx1", W_KX'(rx1[0]), 'h201);
        chk("t5_rx0", W_KX'(rx0[0]), 'h101);
        // orphan result with no jobs issued
        reset_dut();
        y_force = 1; syv = 1; syd = 'h55;
        @(negedge clk);
        chk("t6_sy_ready", W_KX'(s_y_tready), 0);
        chk("t6_err_before", W_KX'(err_orphan), 0);
        step();
        syv = 0;
        @(negedge clk);
        chk("t6_err_set", W_KX'(err_orphan), 1);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_err_clear", W_KX'(err_orphan), 0);
        chk("t6_outstanding", W_KX'(outstanding), 0);
        chk("t6_mkx_valid", W_KX'(m_kx_tvalid), 0);
        y_force = 0;
        // randomized traffic with occasional mid-operation resets
        reset_dut();
        rnd_data = 1; rand_rdy = 1; lat_max = 3; p0 = 60; p1 = 40; n0 = 100000; n1 = 100000;
        upd();
        repeat (3000) begin
            step();
            rst = $urandom_range(499) == 0;
        end
        rst = 0; n0 = 0; n1 = 0; rand_rdy = 0;
        mkr = 1; m0r = 1; m1r = 1; y_en = 1;
        repeat (60) step();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
